// File: rtl/begin_end_stream_ctrl_pkg.sv
// Shared constants and state types for the begin/end block checker.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package begin_end_stream_ctrl_pkg;

  localparam logic [7:0] CH_SPACE  = 8'h20;
  localparam logic [7:0] CH_NUL    = 8'h00;
  localparam logic [7:0] CASE_MASK = 8'h20;

  // lowercase keyword letters, compared after OR-ing in CASE_MASK
  localparam logic [7:0] CH_B = 8'h62;
  localparam logic [7:0] CH_D = 8'h64;
  localparam logic [7:0] CH_E = 8'h65;
  localparam logic [7:0] CH_G = 8'h67;
  localparam logic [7:0] CH_I = 8'h69;
  localparam logic [7:0] CH_N = 8'h6e;
  localparam logic [7:0] CH_LA = 8'h61;
  localparam logic [7:0] CH_LZ = 8'h7a;

  typedef enum logic [3:0] {
    M_START, M_B, M_BE, M_BEG, M_BEGI, M_BEGIN, M_E, M_EN, M_END, M_OTHER
  } m_state_t;

  typedef enum logic [2:0] {
    SQ_IDLE, SQ_S0, SQ_S1, SQ_S2, SQ_S3
  } seq_state_t;

  // ASCII letter test; folding case first keeps it to one range check
  function automatic logic is_letter(input logic [7:0] b);
    logic [7:0] lc;
    lc = b | CASE_MASK;
    return (lc >= CH_LA) && (lc <= CH_LZ);
  endfunction

endpackage

// File: rtl/begin_end_stream_ctrl_kw_matcher.sv
// Keyword matcher: recognises "begin"/"end" tokens one byte at a time.
// Latency: state registered per byte; commit/pending flags are combinational on the current byte.
// Backpressure: none; consumes a byte whenever byte_vld is high.
module begin_end_stream_ctrl_kw_matcher
  import begin_end_stream_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       byte_vld,
  input  logic [7:0] byte_dat,
  output logic       skip,
  output logic       commit_begin,
  output logic       commit_end,
  output logic       pend_begin,
  output logic       pend_end
);

  m_state_t   state, state_next;
  logic [7:0] lc;

  // matcher state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= M_START;
    else       state <= state_next;
  end

  // next-state: walk the keyword trie; anything off-path parks in OTHER until a delimiter
  always_comb begin
    state_next   = state;
    skip         = 1'b0;
    commit_begin = 1'b0;
    commit_end   = 1'b0;
    lc           = byte_dat | CASE_MASK;
    if (byte_vld) begin
      if (byte_dat == CH_NUL) begin
        skip = 1'b1;
      end else if (byte_dat == CH_SPACE) begin
        commit_begin = (state == M_BEGIN);
        commit_end   = (state == M_END);
        state_next   = M_START;
      end else if (is_letter(byte_dat)) begin
        state_next = M_OTHER;
        case (state)
          M_START: begin
            if (lc == CH_B)      state_next = M_B;
            else if (lc == CH_E) state_next = M_E;
          end
          M_B:    if (lc == CH_E) state_next = M_BE;
          M_BE:   if (lc == CH_G) state_next = M_BEG;
          M_BEG:  if (lc == CH_I) state_next = M_BEGI;
          M_BEGI: if (lc == CH_N) state_next = M_BEGIN;
          M_E:    if (lc == CH_N) state_next = M_EN;
          M_EN:   if (lc == CH_D) state_next = M_END;
          default: state_next = M_OTHER;
        endcase
      end else begin
        state_next = M_OTHER;
      end
    end
  end

  // a keyword completed by this byte but not yet delimited still counts toward result
  assign pend_begin = (state_next == M_BEGIN);
  assign pend_end   = (state_next == M_END);

endmodule

// File: rtl/begin_end_stream_ctrl.sv
// Begin/end stream checker: serialises 32-bit words bytewise, tracks nesting depth, reports balance.
// Latency: 5 cycles from word accept to result/error reflecting the word's last byte.
// Backpressure: in_ready high only in IDLE or on the last byte slot, so one word per 4 cycles.
module begin_end_stream_ctrl
  import begin_end_stream_ctrl_pkg::*;
#(
  parameter int DEPTH_W = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [31:0] in_word,
  output logic        in_ready,
  output logic        busy,
  output logic        result,
  output logic        error
);

  seq_state_t         state, state_next;
  logic [31:0]        word_q;
  logic [7:0]         cur_byte;
  logic               proc;
  logic               accept;
  logic               skip, commit_begin, commit_end, pend_begin, pend_end;
  logic [DEPTH_W-1:0] depth, depth_next;
  logic [DEPTH_W:0]   eff;
  logic               error_next, result_next;

  // sequencer state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= SQ_IDLE;
    else       state <= state_next;
  end

  // sequencer next-state and handshake outputs
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    busy       = 1'b1;
    cur_byte   = CH_NUL;
    case (state)
      SQ_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_next = SQ_S0;
      end
      SQ_S0: begin cur_byte = word_q[31:24]; state_next = SQ_S1; end
      SQ_S1: begin cur_byte = word_q[23:16]; state_next = SQ_S2; end
      SQ_S2: begin cur_byte = word_q[15:8];  state_next = SQ_S3; end
      SQ_S3: begin
        cur_byte   = word_q[7:0];
        in_ready   = 1'b1;
        state_next = in_valid ? SQ_S0 : SQ_IDLE;
      end
      default: begin
        busy       = 1'b0;
        state_next = SQ_IDLE;
      end
    endcase
  end

  assign accept = in_valid && in_ready;
  assign proc   = busy;

  // capture the word on accept; bytes are taken from this copy during S0..S3
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       word_q <= '0;
    else if (accept) word_q <= in_word;
  end

  begin_end_stream_ctrl_kw_matcher u_matcher (
    .clk          (clk),
    .reset        (reset),
    .byte_vld     (proc),
    .byte_dat     (cur_byte),
    .skip         (skip),
    .commit_begin (commit_begin),
    .commit_end   (commit_end),
    .pend_begin   (pend_begin),
    .pend_end     (pend_end)
  );

  // depth/error update and balance evaluation; depth freezes once error is set
  always_comb begin
    depth_next  = depth;
    error_next  = error;
    result_next = result;
    eff         = {1'b0, depth};
    if (proc && !skip) begin
      if (!error) begin
        if (commit_begin) begin
          if (&depth) error_next = 1'b1;
          else        depth_next = depth + DEPTH_W'(1);
        end else if (commit_end) begin
          if (depth == '0) error_next = 1'b1;
          else             depth_next = depth - DEPTH_W'(1);
        end
      end
      // one extra bit so a pending "begin" at full depth never wraps to zero
      eff = {1'b0, depth_next};
      if (pend_begin)    eff = {1'b0, depth_next} + {{DEPTH_W{1'b0}}, 1'b1};
      else if (pend_end) eff = {1'b0, depth_next} - {{DEPTH_W{1'b0}}, 1'b1};
      result_next = !error_next && (eff == '0) && !(pend_end && (depth_next == '0));
    end
  end

  // commit depth, sticky error and registered result
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      depth  <= '0;
      error  <= 1'b0;
      result <= 1'b1;
    end else begin
      depth  <= depth_next;
      error  <= error_next;
      result <= result_next;
    end
  end

endmodule
